// File: rtl/taxi_stat_event_collect_pkg.sv
// -----------------------------------------------------------------------------
// taxi_stat_event_collect_pkg
//   Shared types for the statistics event collector.
//   scan_act_t describes what the flush scanner does with the entry under its
//   pointer in a given cycle.
// -----------------------------------------------------------------------------
package taxi_stat_event_collect_pkg;

    typedef enum logic [1:0] {
        SCAN_IDLE    = 2'd0,  // slot free, entry has nothing to report: advance
        SCAN_HOLD    = 2'd1,  // output slot busy: pointer and entry untouched
        SCAN_DROP    = 2'd2,  // flag set on an empty entry: clear flag, advance
        SCAN_CAPTURE = 2'd3   // move the entry into the output register, advance
    } scan_act_t;

endpackage

// File: rtl/taxi_axis_if.sv
// -----------------------------------------------------------------------------
// taxi_axis_if
//   Minimal AXI4-Stream interface carrying data, id and user sidebands.
//   Keep and last are not carried.
//   Modports:
//     src : drives tdata/tvalid/tid/tuser, samples tready
//     snk : samples tdata/tvalid/tid/tuser, drives tready
// -----------------------------------------------------------------------------
interface taxi_axis_if #(
    parameter int DATA_W = 8,
    parameter int ID_W   = 8,
    parameter int USER_W = 1
) ();
    logic [DATA_W-1:0] tdata;
    logic              tvalid;
    logic              tready;
    logic [ID_W-1:0]   tid;
    logic [USER_W-1:0] tuser;

    modport src (output tdata, output tvalid, output tid, output tuser, input tready);
    modport snk (input tdata, input tvalid, input tid, input tuser, output tready);
endinterface

// File: rtl/taxi_stat_event_collect.sv
// -----------------------------------------------------------------------------
// taxi_stat_event_collect
//   Accumulates per-cycle event increments from CNT local sources into
//   saturating accumulators and emits them as statistics-increment messages
//   (tdata = count, tid = ID_BASE + input index) on an AXI4-Stream source.
//   Entries are flushed when a periodic timer flags them, or immediately once
//   an accumulator reaches half scale.
//
//   Ports:
//     clk          block clock
//     rst_n        asynchronous active-low reset
//     stat_inc     per-input increment, [CNT-1:0][INC_W-1:0]
//     stat_valid   per-input increment qualifier
//     m_axis_stat  increment messages (tuser is always 0)
// -----------------------------------------------------------------------------
module taxi_stat_event_collect
    import taxi_stat_event_collect_pkg::*;
#(
    parameter int CNT           = 8,
    parameter int INC_W         = 4,
    parameter int STAT_W        = 16,
    parameter int ID_W          = 10,
    parameter int ID_BASE       = 0,
    parameter int UPDATE_PERIOD = 1024
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [CNT-1:0][INC_W-1:0]  stat_inc,
    input  logic [CNT-1:0]             stat_valid,
    taxi_axis_if.src                   m_axis_stat
);

    localparam int PTR_W = (CNT > 1) ? $clog2(CNT) : 1;
    localparam int TMR_W = (UPDATE_PERIOD > 1) ? $clog2(UPDATE_PERIOD) : 1;
    localparam bit TMR_EN = (UPDATE_PERIOD > 0);
    localparam logic [STAT_W-1:0] ACC_MAX  = {STAT_W{1'b1}};
    localparam logic [PTR_W-1:0]  PTR_LAST = PTR_W'(CNT - 1);
    localparam logic [TMR_W-1:0]  TMR_LAST = TMR_W'((UPDATE_PERIOD > 0) ? UPDATE_PERIOD - 1 : 0);
    localparam logic [ID_W-1:0]   ID_OFS   = ID_W'(ID_BASE);

    // Sum is formed one bit wider so the carry out selects the clamp.
    function automatic logic [STAT_W-1:0] sat_add(input logic [STAT_W-1:0] a,
                                                  input logic [INC_W-1:0]  b);
        logic [STAT_W:0] sum;
        sum = {1'b0, a} + (STAT_W+1)'(b);
        return sum[STAT_W] ? ACC_MAX : sum[STAT_W-1:0];
    endfunction

    logic [STAT_W-1:0] acc [CNT];
    logic [CNT-1:0]    flag;
    logic [PTR_W-1:0]  ptr;
    logic [TMR_W-1:0]  timer;

    logic              out_valid;
    logic [STAT_W-1:0] out_data;
    logic [ID_W-1:0]   out_id;

    logic              slot_free;
    logic              timer_wrap;
    logic [STAT_W-1:0] acc_ptr;
    logic              urgent_ptr;
    scan_act_t         scan_act;
    logic [CNT-1:0]    ptr_onehot;
    logic [CNT-1:0]    cap_sel;
    logic [CNT-1:0]    flag_clr;

    assign slot_free  = !out_valid || m_axis_stat.tready;
    assign timer_wrap = TMR_EN && (timer == TMR_LAST);
    assign acc_ptr    = acc[ptr];
    // Half-full entries bypass the timer so they cannot creep up to saturation
    // while waiting for the next periodic sweep.
    assign urgent_ptr = acc_ptr[STAT_W-1];
    assign ptr_onehot = CNT'(1) << ptr;

    always_comb begin
        scan_act = SCAN_IDLE;
        if (!slot_free) begin
            scan_act = SCAN_HOLD;
        end else if ((flag[ptr] || urgent_ptr) && (acc_ptr != '0)) begin
            scan_act = SCAN_CAPTURE;
        end else if (flag[ptr]) begin
            scan_act = SCAN_DROP;
        end
    end

    always_comb begin
        cap_sel  = '0;
        flag_clr = '0;
        if (scan_act == SCAN_CAPTURE) begin
            cap_sel  = ptr_onehot;
            flag_clr = ptr_onehot;
        end else if (scan_act == SCAN_DROP) begin
            flag_clr = ptr_onehot;
        end
    end

    // Period timer: stays at 0 when periodic flushing is disabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer <= '0;
        end else if (TMR_EN) begin
            timer <= timer_wrap ? '0 : timer + 1'b1;
        end
    end

    // A wrap re-arms every entry; setting wins over a same-cycle clear so a
    // new period is never lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flag <= '0;
        end else if (timer_wrap) begin
            flag <= '1;
        end else begin
            flag <= flag & ~flag_clr;
        end
    end

    // Scanner pointer walks continuously while the output can accept work.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (scan_act != SCAN_HOLD) begin
            ptr <= (ptr == PTR_LAST) ? '0 : ptr + 1'b1;
        end
    end

    // On capture the entry restarts from the same-cycle increment, if any.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int n = 0; n < CNT; n++) begin
                acc[n] <= '0;
            end
        end else begin
            for (int n = 0; n < CNT; n++) begin
                if (cap_sel[n]) begin
                    acc[n] <= stat_valid[n] ? STAT_W'(stat_inc[n]) : '0;
                end else if (stat_valid[n]) begin
                    acc[n] <= sat_add(acc[n], stat_inc[n]);
                end
            end
        end
    end

    // Output register: loads on capture, otherwise drains on tready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_id    <= '0;
        end else if (scan_act == SCAN_CAPTURE) begin
            out_valid <= 1'b1;
            out_data  <= acc_ptr;
            out_id    <= ID_OFS + ID_W'(ptr);
        end else if (m_axis_stat.tready) begin
            out_valid <= 1'b0;
        end
    end

    assign m_axis_stat.tvalid = out_valid;
    assign m_axis_stat.tdata  = out_data;
    assign m_axis_stat.tid    = out_id;
    assign m_axis_stat.tuser  = '0;

endmodule
